// File: rtl/boot_copier_if.sv
// Byte-wide request/acknowledge bus that the boot copier uses to move an image from flash into RAM.
interface boot_copier_if;
  logic        bus_req;
  logic        bus_rw;
  logic [1:0]  bus_len;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        bus_exception;

  modport master (
    output bus_req, bus_rw, bus_len, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack, bus_exception
  );

  modport slave (
    input  bus_req, bus_rw, bus_len, bus_addr, bus_wdata,
    output bus_rdata, bus_ack, bus_exception
  );
endinterface

// File: rtl/boot_copier.sv
// Copies LENGTH bytes from SRC_BASE to DST_BASE one byte at a time, then releases the CPU.
// Each bus transaction is followed by one idle cycle, and a bus fault parks the block in ERR.
`ifndef FLASH_INIT
`define FLASH_INIT 32'h0000_0000
`endif
`ifndef RAM_INIT
`define RAM_INIT 32'h0000_0000
`endif

module boot_copier #(
  parameter logic [31:0] SRC_BASE = `FLASH_INIT,
  parameter logic [31:0] DST_BASE = `RAM_INIT,
  parameter int unsigned LENGTH   = 261
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  boot_copier_if.master bus,
  output logic          done,
  output logic          error,
  output logic          cpu_run
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_DONE, S_ERR
  } state_e;

  localparam logic [15:0] LEN16 = 16'(LENGTH);

  state_e      state_q, state_d;
  logic [31:0] src_ptr_q, src_ptr_d;
  logic [31:0] dst_ptr_q, dst_ptr_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  data_reg_q, data_reg_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_rw_q, bus_rw_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Next-state and next-output computation; outputs are derived from the next state so they leave flops.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    data_reg_d = data_reg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (LEN16 != 16'd0) begin
            state_d   = S_RD;
            src_ptr_d = SRC_BASE;
            dst_ptr_d = DST_BASE;
            count_d   = 16'd0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (bus.bus_ack) begin
          if (bus.bus_exception) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_RD_GAP;
            data_reg_d = bus.bus_rdata;
          end
        end else begin
          state_d = S_RD;
        end
      end
      S_RD_GAP: state_d = S_WR;
      S_WR: begin
        if (bus.bus_ack) begin
          if (bus.bus_exception) begin
            state_d = S_ERR;
          end else begin
            state_d   = S_WR_GAP;
            src_ptr_d = src_ptr_q + 32'd1;
            dst_ptr_d = dst_ptr_q + 32'd1;
            count_d   = count_q + 16'd1;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_WR_GAP: begin
        if (count_q == LEN16) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    bus_req_d = (state_d == S_RD) || (state_d == S_WR);
    bus_rw_d  = (state_d == S_WR) || (state_d == S_WR_GAP);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERR);
    case (state_d)
      S_RD, S_RD_GAP: bus_addr_d = src_ptr_d;
      S_WR, S_WR_GAP: bus_addr_d = dst_ptr_d;
      default:        bus_addr_d = 32'd0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= SRC_BASE;
      dst_ptr_q  <= DST_BASE;
      count_q    <= 16'd0;
      data_reg_q <= 8'd0;
      bus_req_q  <= 1'b0;
      bus_rw_q   <= 1'b0;
      bus_addr_q <= 32'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      data_reg_q <= data_reg_d;
      bus_req_q  <= bus_req_d;
      bus_rw_q   <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_rw    = bus_rw_q;
  assign bus.bus_len   = 2'b00;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = data_reg_q;
  assign done          = done_q;
  assign error         = error_q;
  assign cpu_run       = done_q;
endmodule

// File: tb/tb_boot_copier.sv
// Scoreboard bench: the expected bus transactions of each copy are queued up front, and a bus-slave
// monitor pops one for every request the copier raises, answering with the modelled wait/fault.
module tb_boot_copier;
  localparam logic [31:0] A_SRC = 32'h0000_0100;
  localparam logic [31:0] A_DST = 32'h0000_0200;
  localparam int          A_LEN = 4;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  data;
    int          waits;
    logic        fault;
  } txn_t;

  logic clk = 1'b0;
  logic a_rstn, g_rstn;
  logic a_start, b_start, c_start;
  logic a_done, a_error, a_run;
  logic b_done, b_error, b_run;
  logic c_done, c_error, c_run;

  boot_copier_if a_if ();
  boot_copier_if b_if ();
  boot_copier_if c_if ();

  boot_copier #(.SRC_BASE(A_SRC), .DST_BASE(A_DST), .LENGTH(A_LEN)) u_a (
    .clk(clk), .resetn(a_rstn), .start(a_start), .bus(a_if),
    .done(a_done), .error(a_error), .cpu_run(a_run));

  boot_copier #(.SRC_BASE(32'hFFFF_FFFF), .DST_BASE(32'h0000_0010), .LENGTH(2)) u_b (
    .clk(clk), .resetn(g_rstn), .start(b_start), .bus(b_if),
    .done(b_done), .error(b_error), .cpu_run(b_run));

  boot_copier #(.SRC_BASE(32'h0000_0040), .DST_BASE(32'h0000_0080), .LENGTH(0)) u_c (
    .clk(clk), .resetn(g_rstn), .start(c_start), .bus(c_if),
    .done(c_done), .error(c_error), .cpu_run(c_run));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference data and scoreboard for instance A.
  logic [7:0] src_mem [A_LEN];
  txn_t       exp_q [$];
  txn_t       cur;
  bit         busy, was_ack;
  int         wait_cnt, writes_done;

  // Bus slave + monitor for A: pops expectations, enforces stability while waiting and the idle gap.
  always @(negedge clk) begin
    if (!a_rstn) begin
      busy = 1'b0; was_ack = 1'b0;
      a_if.bus_ack = 1'b0; a_if.bus_exception = 1'b0;
    end else if (was_ack) begin
      check("gap_after_ack", {31'd0, a_if.bus_req}, 32'd0);
      was_ack = 1'b0;
      a_if.bus_ack = 1'b0; a_if.bus_exception = 1'b0;
    end else if (a_if.bus_req) begin
      a_if.bus_ack = 1'b0; a_if.bus_exception = 1'b0;
      if (!busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", {31'd0, a_if.bus_req}, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          busy = 1'b1; wait_cnt = 0;
          check("txn_rw", {31'd0, a_if.bus_rw}, {31'd0, cur.rw});
          check("txn_addr", a_if.bus_addr, cur.addr);
          check("txn_len", {30'd0, a_if.bus_len}, 32'd0);
          if (cur.rw) check("txn_wdata", {24'd0, a_if.bus_wdata}, {24'd0, cur.data});
        end
      end else begin
        check("hold_addr", a_if.bus_addr, cur.addr);
        check("hold_rw", {31'd0, a_if.bus_rw}, {31'd0, cur.rw});
      end
      if (busy) begin
        if (wait_cnt == cur.waits) begin
          a_if.bus_ack = 1'b1;
          a_if.bus_exception = cur.fault;
          a_if.bus_rdata = cur.rw ? 8'($urandom) : cur.data;
          if (cur.rw && !cur.fault) writes_done++;
          busy = 1'b0; was_ack = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      // Idle/gap/terminal states must ignore stray acks and faults.
      a_if.bus_ack = ($urandom_range(0, 2) == 0);
      a_if.bus_exception = 1'($urandom);
      a_if.bus_rdata = 8'($urandom);
    end
  end

  // Zero-wait slave for B; records read and write addresses.
  logic [31:0] b_rd [$];
  logic [31:0] b_wr [$];
  always @(negedge clk) begin
    b_if.bus_ack = b_if.bus_req;
    b_if.bus_exception = 1'b0;
    b_if.bus_rdata = 8'h5A;
    if (b_if.bus_req) begin
      if (b_if.bus_rw) b_wr.push_back(b_if.bus_addr);
      else b_rd.push_back(b_if.bus_addr);
    end
  end

  bit c_req_seen = 1'b0;
  always @(negedge clk) if (c_if.bus_req) c_req_seen = 1'b1;

  task automatic chk_reset_outs();
    check("rst_ctrl", {27'd0, a_if.bus_req, a_if.bus_rw, a_done, a_error, a_run}, 32'd0);
    check("rst_addr", a_if.bus_addr, 32'd0);
    check("rst_wdata", {24'd0, a_if.bus_wdata}, 32'd0);
  endtask

  // Reset is asserted between clock edges so the outputs must clear with no edge.
  task automatic do_reset();
    @(negedge clk);
    a_start = 1'b0;
    #2 a_rstn = 1'b0;
    #1 chk_reset_outs();
    @(negedge clk);
    @(negedge clk);
    a_rstn = 1'b1;
  endtask

  task automatic fill_q(input int wmode, input int fault_idx, output int w_sum,
                        output int pushed, output int exp_wr, output bit faulted);
    txn_t t;
    w_sum = 0; pushed = 0; exp_wr = 0; faulted = 1'b0;
    exp_q.delete();
    writes_done = 0;
    for (int i = 0; i < A_LEN && !faulted; i++) begin
      for (int k = 0; k < 2 && !faulted; k++) begin
        t.rw    = (k == 1);
        t.addr  = (k == 1) ? A_DST + 32'(i) : A_SRC + 32'(i);
        t.data  = src_mem[i];
        t.waits = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
        t.fault = (pushed == fault_idx);
        exp_q.push_back(t);
        w_sum += t.waits;
        pushed++;
        faulted = t.fault;
        if (k == 1 && !t.fault) exp_wr++;
      end
    end
  endtask

  task automatic run_copy(input int wmode, input int fault_idx, input bit rand_data, input bit with_reset);
    int  w_sum, pushed, exp_wr, n, exp_n;
    bit  faulted, req_after;
    if (with_reset) do_reset();
    if (rand_data) foreach (src_mem[i]) src_mem[i] = 8'($urandom);
    fill_q(wmode, fault_idx, w_sum, pushed, exp_wr, faulted);
    a_start = 1'b1;
    @(posedge clk);
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (a_done || a_error) break;
      @(posedge clk);
    end
    // Every transaction costs 1 cycle plus its waits, with one idle cycle after each completed one.
    exp_n = w_sum + pushed + (pushed - 1) + (faulted ? 0 : 1);
    check("cycles_to_end", 32'(n), 32'(exp_n));
    check("done", {31'd0, a_done}, {31'd0, !faulted});
    check("error", {31'd0, a_error}, {31'd0, faulted});
    check("cpu_run", {31'd0, a_run}, {31'd0, !faulted});
    check("bytes_written", 32'(writes_done), 32'(exp_wr));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    req_after = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_if.bus_req) req_after = 1'b1;
    end
    check("no_req_after_end", {31'd0, req_after}, 32'd0);
    check("sticky_flags", {30'd0, a_done, a_error}, {30'd0, !faulted, faulted});
    check("end_addr", a_if.bus_addr, 32'd0);
  endtask

  initial begin
    int  w_sum, pushed, exp_wr, fidx, k;
    bit  faulted, found;
    a_rstn = 1'b0; g_rstn = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    b_if.bus_ack = 1'b0; b_if.bus_exception = 1'b0; b_if.bus_rdata = 8'd0;
    c_if.bus_ack = 1'b0; c_if.bus_exception = 1'b0; c_if.bus_rdata = 8'd0;
    a_if.bus_rdata = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    a_rstn = 1'b1; g_rstn = 1'b1;

    // Zero-length copy: done on the very edge that samples start.
    @(negedge clk);
    check("len0_done_before", {31'd0, c_done}, 32'd0);
    c_start = 1'b1;
    @(posedge clk);
    #1 check("len0_done", {30'd0, c_done, c_run}, 32'd3);

    // Source pointer wrap.
    b_start = 1'b1;
    for (k = 0; k < 100 && !b_done; k++) @(negedge clk);
    check("wrap_done", {31'd0, b_done}, 32'd1);
    check("wrap_nreads", 32'(b_rd.size()), 32'd2);
    if (b_rd.size() == 2) begin
      check("wrap_rd0", b_rd[0], 32'hFFFF_FFFF);
      check("wrap_rd1", b_rd[1], 32'h0000_0000);
    end
    if (b_wr.size() == 2) check("wrap_wr1", b_wr[1], 32'h0000_0011);

    // Directed copies of A1..A4.
    src_mem[0] = 8'hA1; src_mem[1] = 8'hA2; src_mem[2] = 8'hA3; src_mem[3] = 8'hA4;
    run_copy(0, -1, 1'b0, 1'b1);
    run_copy(3, -1, 1'b0, 1'b1);
    run_copy(0, 3, 1'b0, 1'b1);

    // Reset while writing byte 3, then a full restart.
    do_reset();
    fill_q(0, -1, w_sum, pushed, exp_wr, faulted);
    a_start = 1'b1;
    found = 1'b0;
    for (k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      found = a_if.bus_req && a_if.bus_rw && (a_if.bus_addr == A_DST + 32'd2);
    end
    check("reached_wr_byte3", {31'd0, found}, 32'd1);
    #2 a_rstn = 1'b0;
    a_start = 1'b0;
    #1 chk_reset_outs();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    a_rstn = 1'b1;
    run_copy(1, -1, 1'b1, 1'b0);

    // Randomised copies with random wait states and occasional faults.
    for (int r = 0; r < 10; r++) begin
      fidx = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2 * A_LEN - 1));
      run_copy(-1, fidx, 1'b1, 1'b1);
    end

    check("len0_never_req", {31'd0, c_req_seen}, 32'd0);
    check("len0_sticky", {29'd0, c_done, c_error, c_run}, 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
